mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares a single unified memory port between the hart's instruction-fetch requester and its data (load/store) requester, replacing the combinational imem/dmem model with a variable-latency request/response memory. Sits between `hart` and the memory model. Arbitrates one transaction at a time through a four-state FSM. Data accesses win by default, and a starvation counter guarantees fetch forward progress.

## Interface
- `STARVE_LIMIT`, default 4: maximum consecutive data grants while a fetch is pending; must be 1–15.
- `i_clk`  in  1: global clock, rising edge.
- `i_rst`  in  1: reset, asynchronous active-high.
- `i_imem_req`  in  1: fetch request; held high with a stable address until `o_imem_valid`.
- `i_imem_addr`  in  32: fetch byte address.
- `o_imem_valid`  out  1: one-cycle response pulse.
- `o_imem_rdata`  out  32: fetched word, valid with `o_imem_valid`.
- `i_dmem_req`  in  1: data request; held high with stable fields until `o_dmem_valid`.
- `i_dmem_wen`  in  1: 1 = store, 0 = load.
- `i_dmem_addr`  in  32: data byte address.
- `i_dmem_wdata`  in  32: store data, already lane-shifted.
- `i_dmem_mask`  in  4: byte-lane mask.
- `o_dmem_valid`  out  1: one-cycle response pulse; for a store, this is the write acknowledge.
- `o_dmem_rdata`  out  32: load word, valid with `o_dmem_valid`.
- `o_mem_addr`  out  32: word-aligned address; bits [1:0] are forced to 0.
- `o_mem_ren`  out  1: read strobe.
- `o_mem_wen`  out  1: write strobe; never high together with `o_mem_ren`.
- `o_mem_wdata`  out  32: write data.
- `o_mem_mask`  out  4: byte mask; 4'b1111 for fetches.
- `i_mem_ready`  in  1: memory accepts the request this cycle.
- `i_mem_valid`  in  1: memory completes the accepted request this cycle.
- `i_mem_rdata`  in  32: read data, valid with `i_mem_valid`.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, RESP. At most one transaction is in flight.
- **IDLE arbitration, both requesting:** data is granted unless `starve_cnt == STARVE_LIMIT`; in that case fetch is granted.
- **IDLE arbitration, one requesting:** the single requester is granted.
- **On grant:** addr/wdata/mask/type and the owner bit are latched into registers, and the FSM moves to ISSUE.
- **Starvation counter:**
  - Increments on a data grant while `i_imem_req` is high.
  - Clears on a fetch grant, and on any IDLE cycle with `i_imem_req` low.
  - Saturates at `STARVE_LIMIT`.
- **ISSUE:** drives `o_mem_*` from the latched registers with `ren` or `wen` asserted.
  - `i_mem_ready=1` and `i_mem_valid=0`: go to WAIT.
  - `i_mem_ready=1` and `i_mem_valid=1`: capture `i_mem_rdata` and go to RESP.
  - `i_mem_ready=0`: hold ISSUE with outputs unchanged.
- **WAIT:** `ren`/`wen` are low. On `i_mem_valid`, capture `i_mem_rdata` and go to RESP.
- **RESP:** the owner's `o_*_valid` is 1 and `o_*_rdata` holds the captured word. No arbitration happens in this cycle, so the requester's still-high req is not re-granted. Next state is IDLE.
- **Ignored `i_mem_valid`:** dropped in IDLE, RESP, and ISSUE without `i_mem_ready`.
- **Fetch masking:** a fetch always issues `mask=4'b1111` and a read. Store data and mask pass through unchanged.

## Timing
- **Reset values:** state=IDLE, `starve_cnt=0`, all latched registers 0. Consequently all outputs are 0: `o_mem_*`, `o_*_valid`, `o_*_rdata`.
- **Minimum latency:** req seen in IDLE at cycle 0 → ISSUE at cycle 1 (with ready and valid) → valid pulse at cycle 2 → IDLE at cycle 3. Back-to-back throughput is one transaction per 3 cycles.
- **Response outputs:** `o_*_rdata` is registered and held until the next capture. `o_*_valid` is high for exactly one cycle per grant.
- **Reset mid-transaction:** the transaction is abandoned with no valid pulse. A stale `i_mem_valid` arriving afterwards is ignored because the FSM is in IDLE.
- **Request lowered early:** a requester dropping req after grant does not cancel the transaction; it still completes and pulses valid.

## Structure
- **Shared package `mem_arb_pkg`:**
  - FSM state encoding localparams (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3).
  - `MASK_WORD=4'b1111`.
  - Owner encoding (`OWN_I=1'b0`, `OWN_D=1'b1`).
- **Sub-module `arb_starve_ctr`:** saturating counter with inc/clr inputs and an `at_limit` output, parameterised by `STARVE_LIMIT`.
- **Top level:** FSM, request latches and response registers.

## Test plan
- **Single load:** dmem load to 0x00001002, mask 4'b1100; memory returns ready+valid in the same cycle with rdata 0xABCD0000. Required: `o_mem_addr`=0x00001000, `ren`=1 for one cycle; `o_dmem_valid` pulses 2 cycles after grant with rdata 0xABCD0000.
- **Store with wait states:** store to 0x00002003, mask 4'b1000, wdata 0x5A000000; `i_mem_ready` low for 2 cycles, then `i_mem_valid` 3 cycles later. Required: ISSUE outputs hold stable throughout; exactly one `o_dmem_valid`; `o_mem_ren` never high.
- **Contention:** both requesters are held high continuously with `STARVE_LIMIT=4`. Required: grant order is D,D,D,D,I,D,D,D,D,I.
- **No duplicate grant:** a requester holds req through the RESP cycle and drops it the next cycle. Required: exactly one memory transaction is issued.
- **Reset mid-transaction:** assert `i_rst` in WAIT, then drive `i_mem_valid=1` after release. Required: all outputs are 0, no valid pulse, FSM stays in IDLE.
- **Fetch at unaligned address:** fetch from 0x00000007. Required: `o_mem_addr`=0x00000004, mask 4'b1111, read only.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory-port arbiter.
// Holds the FSM state encoding, the owner encoding, the full-word mask and
// a word-alignment helper. Ports: none (package only).
package mem_arb_pkg;

    // FSM state encoding
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = IDLE,
        StIssue = ISSUE,
        StWait  = WAIT,
        StResp  = RESP
    } arb_state_e;

    // Byte mask used for every instruction fetch
    localparam logic [3:0] MASK_WORD = 4'b1111;

    // Owner of the in-flight transaction
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating starvation counter for the fetch requester.
// Ports:
//   i_clk, i_rst  - clock, asynchronous active-high reset
//   i_inc         - count one data grant made while a fetch was waiting
//   i_clr         - clear (fetch granted, or no fetch pending); wins over i_inc
//   o_at_limit    - counter has reached STARVE_LIMIT
module arb_starve_ctr #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit
);

    localparam logic [3:0] LIMIT_W = 4'(STARVE_LIMIT);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = 4'd0;
        end else if (i_inc && (cnt_q != LIMIT_W)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_at_limit = (cnt_q == LIMIT_W);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one request/response memory port between instruction fetch and
// data load/store. One transaction in flight at a time; data wins ties
// unless fetch has been passed over STARVE_LIMIT times in a row.
// Ports:
//   i_clk, i_rst                         - clock, asynchronous active-high reset
//   i_imem_req/addr, o_imem_valid/rdata  - fetch requester
//   i_dmem_req/wen/addr/wdata/mask,
//   o_dmem_valid/rdata                   - data requester
//   o_mem_addr/ren/wen/wdata/mask        - request to memory (held while in ISSUE)
//   i_mem_ready/valid/rdata              - memory accept / completion
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic        i_imem_req,
    input  logic [31:0] i_imem_addr,
    output logic        o_imem_valid,
    output logic [31:0] o_imem_rdata,

    input  logic        i_dmem_req,
    input  logic        i_dmem_wen,
    input  logic [31:0] i_dmem_addr,
    input  logic [31:0] i_dmem_wdata,
    input  logic [3:0]  i_dmem_mask,
    output logic        o_dmem_valid,
    output logic [31:0] o_dmem_rdata,

    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_ready,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_rdata
);

    arb_state_e  state_q, state_d;
    logic        owner_q, owner_d;
    logic        wen_q, wen_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] irdata_q, irdata_d;
    logic [31:0] drdata_q, drdata_d;

    logic starve_inc;
    logic starve_clr;
    logic starve_at_limit;

    arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_inc     (starve_inc),
        .i_clr     (starve_clr),
        .o_at_limit(starve_at_limit)
    );

    logic grant_d;
    logic grant_i;
    logic capture;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        wen_d      = wen_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        mask_d     = mask_q;
        irdata_d   = irdata_q;
        drdata_d   = drdata_q;
        starve_inc = 1'b0;
        starve_clr = 1'b0;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        capture    = 1'b0;

        case (state_q)
            StIdle: begin
                // Data wins unless fetch has been starved up to the limit
                grant_d = i_dmem_req && !(i_imem_req && starve_at_limit);
                grant_i = i_imem_req && !grant_d;
                if (!i_imem_req) begin
                    starve_clr = 1'b1;
                end
                if (grant_d) begin
                    owner_d    = OWN_D;
                    wen_d      = i_dmem_wen;
                    addr_d     = word_align(i_dmem_addr);
                    wdata_d    = i_dmem_wdata;
                    mask_d     = i_dmem_mask;
                    starve_inc = i_imem_req;
                    state_d    = StIssue;
                end else if (grant_i) begin
                    owner_d    = OWN_I;
                    wen_d      = 1'b0;
                    addr_d     = word_align(i_imem_addr);
                    wdata_d    = 32'h0;
                    mask_d     = MASK_WORD;
                    starve_clr = 1'b1;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                if (i_mem_ready) begin
                    capture = i_mem_valid;
                    state_d = i_mem_valid ? StResp : StWait;
                end
            end
            StWait: begin
                if (i_mem_valid) begin
                    capture = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                // No arbitration here so a still-high req is not re-granted
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (capture) begin
            if (owner_q == OWN_I) begin
                irdata_d = i_mem_rdata;
            end else begin
                drdata_d = i_mem_rdata;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= StIdle;
            owner_q  <= OWN_I;
            wen_q    <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            mask_q   <= 4'h0;
            irdata_q <= 32'h0;
            drdata_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            wen_q    <= wen_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            mask_q   <= mask_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
        end
    end

    assign o_mem_addr   = addr_q;
    assign o_mem_wdata  = wdata_q;
    assign o_mem_mask   = mask_q;
    assign o_mem_ren    = (state_q == StIssue) && !wen_q;
    assign o_mem_wen    = (state_q == StIssue) && wen_q;

    assign o_imem_valid = (state_q == StResp) && (owner_q == OWN_I);
    assign o_dmem_valid = (state_q == StResp) && (owner_q == OWN_D);
    assign o_imem_rdata = irdata_q;
    assign o_dmem_rdata = drdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter. Tests push the expected memory
// requests (in grant order, with the memory's reply and wait states) and the
// expected responses; requester drivers and a single negedge checker that
// also plays the memory do the rest.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_imem_req;
    logic [31:0] i_imem_addr;
    logic        o_imem_valid;
    logic [31:0] o_imem_rdata;
    logic        i_dmem_req;
    logic        i_dmem_wen;
    logic [31:0] i_dmem_addr;
    logic [31:0] i_dmem_wdata;
    logic [3:0]  i_dmem_mask;
    logic        o_dmem_valid;
    logic [31:0] o_dmem_rdata;
    logic [31:0] o_mem_addr;
    logic        o_mem_ren;
    logic        o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_mask;
    logic        i_mem_ready;
    logic        i_mem_valid;
    logic [31:0] i_mem_rdata;

    mem_arbiter #(
        .STARVE_LIMIT(4)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_imem_req  (i_imem_req),
        .i_imem_addr (i_imem_addr),
        .o_imem_valid(o_imem_valid),
        .o_imem_rdata(o_imem_rdata),
        .i_dmem_req  (i_dmem_req),
        .i_dmem_wen  (i_dmem_wen),
        .i_dmem_addr (i_dmem_addr),
        .i_dmem_wdata(i_dmem_wdata),
        .i_dmem_mask (i_dmem_mask),
        .o_dmem_valid(o_dmem_valid),
        .o_dmem_rdata(o_dmem_rdata),
        .o_mem_addr  (o_mem_addr),
        .o_mem_ren   (o_mem_ren),
        .o_mem_wen   (o_mem_wen),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_mask  (o_mem_mask),
        .i_mem_ready (i_mem_ready),
        .i_mem_valid (i_mem_valid),
        .i_mem_rdata (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int          hold;     // 0: hold req until valid; N: drop after N cycles
    } op_t;

    typedef struct {
        logic        wen;
        logic [31:0] addr;     // expected aligned address
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] rdata;    // what the memory returns
        int          rdy_wait; // ISSUE cycles with ready low
        int          vld_wait; // cycles from accept to valid (0 = same cycle)
    } mem_t;

    typedef struct {
        logic        own;
        logic [31:0] rdata;
    } rsp_t;

    op_t  dq[$];
    op_t  iq[$];
    mem_t exp_mem[$];
    rsp_t exp_rsp[$];

    int   n_vec = 0;
    int   n_err = 0;
    int   d_tmo = 0;
    int   i_tmo = 0;
    int   zchk_req = 0;
    int   end_req = 0;
    bit   manual = 1'b0;
    logic manual_valid = 1'b0;

    // Checker / memory model state (written only by the checker process)
    int          chk_cyc = 0;
    int          chk_rcnt = 0;
    int          chk_vcnt = 0;
    int          chk_due = -1;
    int          chk_dseen = 0;
    int          chk_iseen = 0;
    int          chk_zseen = 0;
    int          chk_eseen = 0;
    bit          chk_pend = 1'b0;
    logic [31:0] chk_prd = 32'h0;
    mem_t        chk_m;
    rsp_t        chk_r;
    logic        chk_own;
    logic [31:0] chk_rd;

    // Data requester driver
    initial begin
        op_t op;
        int  n;
        i_dmem_req = 1'b0; i_dmem_wen = 1'b0; i_dmem_addr = 32'h0;
        i_dmem_wdata = 32'h0; i_dmem_mask = 4'h0;
        forever begin
            @(posedge i_clk); #1;
            while (dq.size() != 0) begin
                op = dq.pop_front();
                i_dmem_wen = op.wen; i_dmem_addr = op.addr;
                i_dmem_wdata = op.wdata; i_dmem_mask = op.mask; i_dmem_req = 1'b1;
                if (op.hold != 0) begin
                    repeat (op.hold) @(posedge i_clk);
                    #1;
                end else begin
                    n = 0;
                    do begin @(posedge i_clk); #1; n++; end
                    while (!o_dmem_valid && n < 200);
                    if (!o_dmem_valid) d_tmo++;
                    // keep req high through the RESP cycle
                    @(posedge i_clk); #1;
                end
            end
            i_dmem_req = 1'b0;
        end
    end

    // Fetch requester driver
    initial begin
        op_t op;
        int  n;
        i_imem_req = 1'b0; i_imem_addr = 32'h0;
        forever begin
            @(posedge i_clk); #1;
            while (iq.size() != 0) begin
                op = iq.pop_front();
                i_imem_addr = op.addr; i_imem_req = 1'b1;
                n = 0;
                do begin @(posedge i_clk); #1; n++; end
                while (!o_imem_valid && n < 200);
                if (!o_imem_valid) i_tmo++;
                @(posedge i_clk); #1;
            end
            i_imem_req = 1'b0;
        end
    end

    // Monitor, scoreboard and memory model
    initial begin
        i_mem_ready = 1'b0; i_mem_valid = 1'b0; i_mem_rdata = 32'hDEADBEEF;
        forever begin
            @(negedge i_clk);
            chk_cyc++;
            i_mem_ready = 1'b0; i_mem_valid = 1'b0; i_mem_rdata = 32'hDEADBEEF;

            if (d_tmo != chk_dseen) begin
                n_vec++; n_err++; chk_dseen = d_tmo;
                $display("FAIL dmem_timeout: got no o_dmem_valid, want one within 200 cycles");
            end
            if (i_tmo != chk_iseen) begin
                n_vec++; n_err++; chk_iseen = i_tmo;
                $display("FAIL imem_timeout: got no o_imem_valid, want one within 200 cycles");
            end

            if (zchk_req != chk_zseen) begin
                chk_zseen = zchk_req; n_vec++;
                if ({o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata, o_mem_mask, o_imem_valid,
                     o_imem_rdata, o_dmem_valid, o_dmem_rdata} != '0) begin
                    n_err++;
                    $display("FAIL zero_outputs: got addr=%h ren=%b wen=%b wd=%h m=%h iv=%b ird=%h dv=%b drd=%h, want all 0",
                             o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata, o_mem_mask,
                             o_imem_valid, o_imem_rdata, o_dmem_valid, o_dmem_rdata);
                end
            end

            if (o_imem_valid || o_dmem_valid) begin
                n_vec++;
                if (o_imem_valid && o_dmem_valid) begin
                    n_err++;
                    $display("FAIL rsp_both: got both valids high, want at most one");
                end else if (exp_rsp.size() == 0) begin
                    n_err++;
                    $display("FAIL rsp_unexpected: got valid (d=%b), want none", o_dmem_valid);
                end else begin
                    chk_r   = exp_rsp.pop_front();
                    chk_own = o_dmem_valid ? OWN_D : OWN_I;
                    chk_rd  = o_dmem_valid ? o_dmem_rdata : o_imem_rdata;
                    if (chk_own !== chk_r.own || chk_rd !== chk_r.rdata || chk_cyc != chk_due) begin
                        n_err++;
                        $display("FAIL rsp: got own=%0d rdata=%h cyc=%0d, want own=%0d rdata=%h cyc=%0d",
                                 chk_own, chk_rd, chk_cyc, chk_r.own, chk_r.rdata, chk_due);
                    end
                end
            end

            if (manual) begin
                chk_pend = 1'b0; chk_rcnt = 0;
                i_mem_valid = manual_valid;
            end else if (chk_pend) begin
                if (o_mem_ren || o_mem_wen) begin
                    n_vec++; n_err++;
                    $display("FAIL wait_strobe: got ren=%b wen=%b, want 0 0", o_mem_ren, o_mem_wen);
                end
                if (chk_vcnt == 0) begin
                    i_mem_valid = 1'b1; i_mem_rdata = chk_prd;
                    chk_pend = 1'b0; chk_due = chk_cyc + 1;
                end else begin
                    chk_vcnt--;
                end
            end else if (o_mem_ren || o_mem_wen) begin
                n_vec++;
                if (exp_mem.size() == 0) begin
                    n_err++;
                    $display("FAIL issue_unexpected: got addr=%h ren=%b wen=%b, want no request",
                             o_mem_addr, o_mem_ren, o_mem_wen);
                    i_mem_ready = 1'b1; i_mem_valid = 1'b1;
                end else begin
                    chk_m = exp_mem[0];
                    if (o_mem_addr !== chk_m.addr || o_mem_mask !== chk_m.mask ||
                        o_mem_ren !== !chk_m.wen || o_mem_wen !== chk_m.wen ||
                        (chk_m.wen && o_mem_wdata !== chk_m.wdata)) begin
                        n_err++;
                        $display("FAIL issue: got addr=%h m=%h ren=%b wen=%b wd=%h, want addr=%h m=%h ren=%b wen=%b wd=%h",
                                 o_mem_addr, o_mem_mask, o_mem_ren, o_mem_wen, o_mem_wdata,
                                 chk_m.addr, chk_m.mask, !chk_m.wen, chk_m.wen, chk_m.wdata);
                    end
                    if (chk_rcnt < chk_m.rdy_wait) begin
                        chk_rcnt++;
                    end else begin
                        chk_rcnt = 0;
                        void'(exp_mem.pop_front());
                        i_mem_ready = 1'b1;
                        if (chk_m.vld_wait == 0) begin
                            i_mem_valid = 1'b1; i_mem_rdata = chk_m.rdata;
                            chk_due = chk_cyc + 1;
                        end else begin
                            chk_pend = 1'b1; chk_vcnt = chk_m.vld_wait - 1;
                            chk_prd = chk_m.rdata;
                        end
                    end
                end
            end

            if (end_req != chk_eseen) begin
                chk_eseen = end_req; n_vec++;
                if (exp_mem.size() != 0 || exp_rsp.size() != 0) begin
                    n_err++;
                    $display("FAIL leftover: got %0d requests %0d responses outstanding, want 0 0",
                             exp_mem.size(), exp_rsp.size());
                end
            end
        end
    end

    task automatic drain();
        for (int n = 0; n < 400; n++) begin
            @(negedge i_clk);
            if (dq.size() == 0 && iq.size() == 0 && exp_mem.size() == 0 &&
                exp_rsp.size() == 0 && !i_dmem_req && !i_imem_req) break;
        end
        repeat (3) @(negedge i_clk);
    endtask

    initial begin
        int di;
        int ii;
        i_rst = 1'b1;
        zchk_req++;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        zchk_req++;
        repeat (2) @(negedge i_clk);

        // Single load, ready+valid together
        exp_mem.push_back('{1'b0, 32'h0000_1000, 32'h0, 4'b1100, 32'hABCD_0000, 0, 0});
        exp_rsp.push_back('{OWN_D, 32'hABCD_0000});
        dq.push_back('{1'b0, 32'h0000_1002, 32'h0, 4'b1100, 0});
        drain();

        // Store with wait states on both accept and completion
        exp_mem.push_back('{1'b1, 32'h0000_2000, 32'h5A00_0000, 4'b1000, 32'h0000_0000, 2, 3});
        exp_rsp.push_back('{OWN_D, 32'h0000_0000});
        dq.push_back('{1'b1, 32'h0000_2003, 32'h5A00_0000, 4'b1000, 0});
        drain();

        // Contention: D,D,D,D,I,D,D,D,D,I
        di = 0; ii = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 4 || k == 9) begin
                iq.push_back('{1'b0, 32'h0000_0802 + 32'(8 * ii), 32'h0, 4'h0, 0});
                exp_mem.push_back('{1'b0, 32'h0000_0800 + 32'(8 * ii), 32'h0, 4'b1111,
                                    32'hE000_0000 + 32'(ii), k % 2, k % 3});
                exp_rsp.push_back('{OWN_I, 32'hE000_0000 + 32'(ii)});
                ii++;
            end else begin
                dq.push_back('{1'(di % 2), 32'h0000_0101 + 32'(16 * di),
                               32'h1111_0000 + 32'(di), 4'b0011, 0});
                exp_mem.push_back('{1'(di % 2), 32'h0000_0100 + 32'(16 * di),
                                    32'h1111_0000 + 32'(di), 4'b0011,
                                    32'hD000_0000 + 32'(di), k % 2, k % 3});
                exp_rsp.push_back('{OWN_D, 32'hD000_0000 + 32'(di)});
                di++;
            end
        end
        drain();

        // Req held through RESP, dropped after: exactly one transaction
        exp_mem.push_back('{1'b0, 32'h0000_3000, 32'h0, 4'b1111, 32'h1234_5678, 0, 0});
        exp_rsp.push_back('{OWN_D, 32'h1234_5678});
        dq.push_back('{1'b0, 32'h0000_3000, 32'h0, 4'b1111, 0});
        drain();

        // Reset while in WAIT, then a stale memory valid
        exp_mem.push_back('{1'b0, 32'h0000_4000, 32'h0, 4'b1111, 32'h7777_7777, 0, 10});
        dq.push_back('{1'b0, 32'h0000_4000, 32'h0, 4'b1111, 2});
        for (int n = 0; n < 20; n++) begin
            @(negedge i_clk);
            if (exp_mem.size() == 0) break;
        end
        manual = 1'b1;
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        manual_valid = 1'b1;
        zchk_req++;
        repeat (3) @(negedge i_clk);
        zchk_req++;
        @(negedge i_clk);
        manual_valid = 1'b0;
        manual = 1'b0;
        drain();

        // Fetch from an unaligned address
        exp_mem.push_back('{1'b0, 32'h0000_0004, 32'h0, 4'b1111, 32'h0BAD_F00D, 0, 1});
        exp_rsp.push_back('{OWN_I, 32'h0BAD_F00D});
        iq.push_back('{1'b0, 32'h0000_0007, 32'h0, 4'h0, 0});
        drain();

        end_req++;
        repeat (2) @(negedge i_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
